// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and sizing constants for the two-port memory arbiter
//
// Purpose: single home for the arbiter FSM encoding and the default memory
// geometry so the arbiter, its selector and the memory model agree.
// Ports: none (package).

package mem_arb_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 256;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_256x16.sv
// rtl/mem_256x16.sv - single-port synchronous RAM placed beside the arbiter
//
// Purpose: memory the arbiter's m_* bus connects to at the level above it.
// Write at the rising edge; read data is registered and appears the cycle
// after the address, so a write followed by a read of the same word returns
// the new value. Contents are not touched by reset.
// Ports:
//   clk    in   clock
//   addr   in   word address
//   wdata  in   write data
//   we     in   write enable
//   rdata  out  read data for the address presented in the previous cycle

module mem_256x16
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_arbiter_2p_rr_arb2.sv
// rtl/mem_arbiter_2p_rr_arb2.sv - two-way round-robin grant selector
//
// Purpose: picks at most one of two requesters. A lone request wins outright;
// on a tie the side named by the pointer wins. Also returns the pointer value
// to register so that the loser of this cycle is favoured next time.
// Ports:
//   req[1:0]  in   request vector, bit 0 = port A, bit 1 = port B
//   ptr       in   tie-break pointer: 0 favours A, 1 favours B
//   upd       in   grant/update strobe; no grant and no pointer change when low
//   gnt[1:0]  out  one-hot (or zero) grant vector
//   ptr_nxt   out  pointer value for the next cycle

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

  always_comb begin
    gnt     = 2'b00;
    ptr_nxt = ptr;
    if (upd) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
      // Point at the side that did not just win; no grant leaves it alone.
      if (gnt[0]) begin
        ptr_nxt = 1'b1;
      end else if (gnt[1]) begin
        ptr_nxt = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_2p.sv
// rtl/mem_arbiter_2p.sv - two-port round-robin arbiter in front of a single-port memory
//
// Purpose: after reset optionally clears every memory word, then grants one
// requester per cycle onto the memory bus, round-robin on contention, and
// returns read data with a one-cycle valid strobe to the port that asked.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   a_req/b_req        in   1       access request, held until granted
//   a_we/b_we          in   1       1 = write, 0 = read
//   a_addr/b_addr      in   ADDR_W  word address
//   a_wdata/b_wdata    in   DATA_W  write data
//   a_gnt/b_gnt        out  1       access accepted this cycle
//   a_rvalid/b_rvalid  out  1       read data valid (cycle after a read grant)
//   a_rdata/b_rdata    out  DATA_W  read data, zero when not valid
//   m_addr/m_wdata/m_we out         memory command bus
//   m_rdata            in   DATA_W  memory read data, one cycle after address
//   init_done          out  1       clear finished, requests being served

module mem_arbiter_2p #(
  parameter int CLEAR_ON_RESET = 1,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              init_done
);

  import mem_arb_pkg::*;

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic              ptr;
  logic              ptr_nxt;
  logic [1:0]        gnt;
  logic              run;
  logic              last_clear;
  logic              a_rd_pend;
  logic              b_rd_pend;

  assign run        = (state == ST_RUN);
  // Without clearing, the init state is a single idle cycle.
  assign last_clear = (CLEAR_ON_RESET == 0) || (init_cnt == {ADDR_W{1'b1}});

  rr_arb2 u_rr_arb2 (
    .req     ({b_req, a_req}),
    .ptr     (ptr),
    .upd     (run),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      ptr       <= 1'b0;
      a_rd_pend <= 1'b0;
      b_rd_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!run) begin
        init_cnt <= init_cnt + 1'b1;
      end
      ptr       <= ptr_nxt;
      a_rd_pend <= gnt[0] & ~a_we;
      b_rd_pend <= gnt[1] & ~b_we;
    end
  end

  // The memory bus is also held at zero while reset is asserted, otherwise
  // the init state would present a clear-write of word 0 during reset.
  always_comb begin
    state_nxt = state;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    init_done = 1'b0;
    if (rst_n) begin
      case (state)
        ST_INIT: begin
          if (CLEAR_ON_RESET != 0) begin
            m_we   = 1'b1;
            m_addr = init_cnt;
          end
          if (last_clear) begin
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          init_done = 1'b1;
          if (gnt[0]) begin
            m_we    = a_we;
            m_addr  = a_addr;
            m_wdata = a_wdata;
          end else if (gnt[1]) begin
            m_we    = b_we;
            m_addr  = b_addr;
            m_wdata = b_wdata;
          end
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  assign a_rvalid = a_rd_pend;
  assign b_rvalid = b_rd_pend;
  assign a_rdata  = a_rd_pend ? m_rdata : '0;
  assign b_rdata  = b_rd_pend ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// tb/tb_mem_arbiter_2p.sv - directed self-checking bench for mem_arbiter_2p

module tb_mem_arbiter_2p;

  logic        clk;
  logic        rst_n;
  logic        rst1_n;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;

  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, m_we, init_done;
  logic [15:0] a_rdata, b_rdata, m_wdata, m_rdata;
  logic [7:0]  m_addr;

  logic        a_gnt1, a_rvalid1, b_gnt1, b_rvalid1, m_we1, init_done1;
  logic [15:0] a_rdata1, b_rdata1, m_wdata1, m_rdata1;
  logic [7:0]  m_addr1;

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter_2p #(.CLEAR_ON_RESET(1), .ADDR_W(8), .DATA_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata),
    .init_done(init_done)
  );

  mem_256x16 u_mem (.clk(clk), .addr(m_addr), .wdata(m_wdata), .we(m_we), .rdata(m_rdata));

  mem_arbiter_2p #(.CLEAR_ON_RESET(0), .ADDR_W(8), .DATA_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst1_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
    .m_addr(m_addr1), .m_wdata(m_wdata1), .m_we(m_we1), .m_rdata(m_rdata1),
    .init_done(init_done1)
  );

  mem_256x16 u_mem1 (.clk(clk), .addr(m_addr1), .wdata(m_wdata1), .we(m_we1), .rdata(m_rdata1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  typedef struct {
    logic        a_req, a_we;
    logic [7:0]  a_addr;
    logic [15:0] a_wdata;
    logic        b_req, b_we;
    logic [7:0]  b_addr;
    logic [15:0] b_wdata;
    logic [1:0]  gnt;      // {b_gnt, a_gnt}
    logic        m_we;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;
    logic        a_rv;
    logic [15:0] a_rd;
    logic        b_rv;
    logic [15:0] b_rd;
  } vec_t;

  vec_t vt [17];

  function automatic vec_t mk(
    input logic ar, input logic aw, input logic [7:0] aa, input logic [15:0] ad,
    input logic br, input logic bw, input logic [7:0] ba, input logic [15:0] bd,
    input logic [1:0] g, input logic mw, input logic [7:0] ma, input logic [15:0] md,
    input logic arv, input logic [15:0] ard, input logic brv, input logic [15:0] brd);
    vec_t v;
    v.a_req = ar;  v.a_we = aw;  v.a_addr = aa;  v.a_wdata = ad;
    v.b_req = br;  v.b_we = bw;  v.b_addr = ba;  v.b_wdata = bd;
    v.gnt = g;     v.m_we = mw;  v.m_addr = ma;  v.m_wdata = md;
    v.a_rv = arv;  v.a_rd = ard; v.b_rv = brv;   v.b_rd = brd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
  endtask

  initial begin
    //              A: req we addr  wdata    B: req we addr  wdata    gnt   m: we addr  wdata    A: rv rdata   B: rv rdata
    vt[0]  = mk(1, 0, 8'h7F, 16'h0000, 1, 0, 8'h22, 16'h0000, 2'b01, 0, 8'h7F, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vt[1]  = mk(0, 0, 8'h00, 16'h0000, 1, 0, 8'h22, 16'h0000, 2'b10, 0, 8'h22, 16'h0000, 1, 16'h0000, 0, 16'h0000);
    vt[2]  = mk(1, 1, 8'h10, 16'h1234, 0, 0, 8'h00, 16'h0000, 2'b01, 1, 8'h10, 16'h1234, 0, 16'h0000, 1, 16'h0000);
    vt[3]  = mk(0, 0, 8'h00, 16'h0000, 1, 0, 8'h10, 16'h0000, 2'b10, 0, 8'h10, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vt[4]  = mk(1, 0, 8'h10, 16'h0000, 1, 1, 8'h55, 16'hABCD, 2'b01, 0, 8'h10, 16'h0000, 0, 16'h0000, 1, 16'h1234);
    vt[5]  = mk(1, 0, 8'h10, 16'h0000, 1, 1, 8'h55, 16'hABCD, 2'b10, 1, 8'h55, 16'hABCD, 1, 16'h1234, 0, 16'h0000);
    vt[6]  = mk(1, 0, 8'h10, 16'h0000, 1, 1, 8'h55, 16'hABCD, 2'b01, 0, 8'h10, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vt[7]  = mk(1, 0, 8'h10, 16'h0000, 1, 1, 8'h55, 16'hABCD, 2'b10, 1, 8'h55, 16'hABCD, 1, 16'h1234, 0, 16'h0000);
    vt[8]  = mk(1, 0, 8'h10, 16'h0000, 1, 1, 8'h55, 16'hABCD, 2'b01, 0, 8'h10, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vt[9]  = mk(1, 0, 8'h10, 16'h0000, 1, 1, 8'h55, 16'hABCD, 2'b10, 1, 8'h55, 16'hABCD, 1, 16'h1234, 0, 16'h0000);
    vt[10] = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 2'b00, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vt[11] = mk(0, 0, 8'h00, 16'h0000, 1, 0, 8'h55, 16'h0000, 2'b10, 0, 8'h55, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vt[12] = mk(1, 0, 8'h55, 16'h0000, 1, 0, 8'h7F, 16'h0000, 2'b01, 0, 8'h55, 16'h0000, 0, 16'h0000, 1, 16'hABCD);
    vt[13] = mk(0, 0, 8'h00, 16'h0000, 1, 0, 8'h7F, 16'h0000, 2'b10, 0, 8'h7F, 16'h0000, 1, 16'hABCD, 0, 16'h0000);
    vt[14] = mk(0, 0, 8'h00, 16'h0000, 1, 1, 8'hFF, 16'hFFFF, 2'b10, 1, 8'hFF, 16'hFFFF, 0, 16'h0000, 1, 16'h0000);
    vt[15] = mk(1, 0, 8'hFF, 16'h0000, 0, 0, 8'h00, 16'h0000, 2'b01, 0, 8'hFF, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vt[16] = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 2'b00, 0, 8'h00, 16'h0000, 1, 16'hFFFF, 0, 16'h0000);

    rst_n  = 1'b0;
    rst1_n = 1'b0;
    drive(vt[0]);

    // Reset state, with both requests already high.
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", {b_gnt, a_gnt}, 2'b00);
    check("rst_mbus", {m_we, m_addr, m_wdata}, 25'h0);
    check("rst_rvalid", {b_rvalid, a_rvalid}, 2'b00);
    check("rst_rdata", {b_rdata, a_rdata}, 32'h0);
    check("rst_init_done", init_done, 1'b0);

    // Clear sequence: 256 write cycles, no grants.
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      check($sformatf("init_cycle_%0d", i),
            {b_gnt, a_gnt, init_done, m_we, m_addr, m_wdata},
            {2'b00, 1'b0, 1'b1, i[7:0], 16'h0000});
      @(posedge clk);
      #1;
    end

    // Run phase vectors; A wins the first tie because the pointer resets to A.
    for (int r = 0; r < 17; r++) begin
      drive(vt[r]);
      @(negedge clk);
      check($sformatf("row%0d_init_done", r), init_done, 1'b1);
      check($sformatf("row%0d_gnt", r), {b_gnt, a_gnt}, vt[r].gnt);
      check($sformatf("row%0d_mbus", r), {m_we, m_addr, m_wdata},
            {vt[r].m_we, vt[r].m_addr, vt[r].m_wdata});
      check($sformatf("row%0d_a_rd", r), {a_rvalid, a_rdata}, {vt[r].a_rv, vt[r].a_rd});
      check($sformatf("row%0d_b_rd", r), {b_rvalid, b_rdata}, {vt[r].b_rv, vt[r].b_rd});
      @(posedge clk);
      #1;
    end

    // Reset during a pending read discards the read-valid at once.
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10; a_wdata = 16'h0000;
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 16'h0000;
    @(negedge clk);
    check("pend_gnt", {b_gnt, a_gnt}, 2'b01);
    @(posedge clk);
    #1;
    a_req = 1'b0;
    check("pend_rvalid", {a_rvalid, a_rdata}, {1'b1, 16'h1234});
    rst_n = 1'b0;
    #1;
    check("pend_rst_rvalid", {a_rvalid, a_rdata}, 17'h0);
    check("pend_rst_init_done", init_done, 1'b0);

    // Reset pulsed at init count 100; the clear restarts at word 0.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_req = 1'b1;
    b_req = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("mid_init_cnt100", {m_we, m_addr}, {1'b1, 8'd100});
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_init_rst_mbus", {m_we, m_addr, m_wdata}, 25'h0);
    check("mid_init_rst_gnt", {b_gnt, a_gnt, init_done}, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_addr0", {m_we, m_addr, m_wdata, b_gnt, a_gnt}, {1'b1, 8'h00, 16'h0000, 2'b00});
    repeat (255) @(posedge clk);
    @(negedge clk);
    check("restart_last", {init_done, m_we, m_addr, b_gnt, a_gnt}, {1'b0, 1'b1, 8'hFF, 2'b00});
    @(posedge clk);
    @(negedge clk);
    check("restart_done_gnt_a", {init_done, b_gnt, a_gnt}, {1'b1, 2'b01});
    @(posedge clk);
    #1;
    a_req = 1'b0;
    b_req = 1'b0;

    // No-clear instance: one idle init cycle, and memory survives reset.
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h33; a_wdata = 16'hBEEF;
    rst1_n = 1'b1;
    @(negedge clk);
    check("nc_first_cycle", {init_done1, m_we1, b_gnt1, a_gnt1}, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    check("nc_done_write", {init_done1, a_gnt1, m_we1, m_addr1, m_wdata1},
          {1'b1, 1'b1, 1'b1, 8'h33, 16'hBEEF});
    @(posedge clk);
    #1;
    a_req = 1'b0; a_we = 1'b0; a_wdata = 16'h0000;
    rst1_n = 1'b0;
    #1;
    check("nc_rst_outputs", {init_done1, a_rvalid1, m_we1}, 3'b000);
    @(posedge clk);
    #1;
    rst1_n = 1'b1;
    a_req = 1'b1;
    @(negedge clk);
    check("nc_init_no_gnt", {init_done1, b_gnt1, a_gnt1}, 3'b000);
    @(posedge clk);
    @(negedge clk);
    check("nc_read_gnt", {init_done1, a_gnt1, m_we1, m_addr1}, {1'b1, 1'b1, 1'b0, 8'h33});
    @(posedge clk);
    #1;
    a_req = 1'b0;
    @(negedge clk);
    check("nc_persist", {a_rvalid1, a_rdata1}, {1'b1, 16'hBEEF});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_2p.md
MEM_ARBITER_2P -- requirements
Module: mem_arbiter_2p

Interface
REQ-001 Parameter CLEAR_ON_RESET, default 1, meaning 1 = zero all 256 words after reset before serving requests.
REQ-002 Parameter ADDR_W, default 8, meaning memory address width (depth 2**ADDR_W = 256).
REQ-003 Parameter DATA_W, default 16, meaning memory word width.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
- CLK  in  1  single clock; all state changes on rising edge.
- RST_N  in  1  asynchronous active-low reset.
REQ-005 The block SHALL provide two requester ports, X = A (port A) and X = B (port B), each with these signals.
- X_REQ  in  1  access request; held until X_GNT.
- X_WE  in  1  1 = write, 0 = read.
- X_ADDR  in  8  word address.
- X_WDATA  in  16  write data.
- X_GNT  out  1  access accepted this cycle.
- X_RVALID  out  1  read data valid.
- X_RDATA  out  16  read data.
REQ-006 The block SHALL provide the following memory-side and status ports.
- M_ADDR  out  8  to memory ADDR.
- M_WDATA  out  16  to memory WDATA.
- M_WE  out  1  to memory WE.
- M_RDATA  in  16  from memory RDATA; valid the cycle after a read address is driven.
- INIT_DONE  out  1  high once clearing is complete and requests are served.

Function
REQ-007 The FSM SHALL have two states, ST_INIT and ST_RUN, and SHALL enter ST_INIT on reset.
REQ-008 In ST_INIT with CLEAR_ON_RESET=1, each cycle: M_WE=1, M_WDATA=0, M_ADDR=8-bit counter; the counter SHALL step 0..255 over exactly 256 cycles.
REQ-009 After the cycle writing address 255, the FSM SHALL go to ST_RUN and INIT_DONE SHALL rise the next cycle; with CLEAR_ON_RESET=0, ST_INIT SHALL last one cycle with M_WE=0.
REQ-010 In ST_INIT, A_GNT and B_GNT SHALL be 0 regardless of REQ.
REQ-011 In ST_RUN, at most one GNT SHALL be high per cycle; GNT is combinational from REQ and the priority pointer.
REQ-012 When only one REQ is high, that port SHALL be granted the same cycle.
REQ-013 When both REQs are high, the port not granted most recently SHALL win; the pointer SHALL update only on a grant and SHALL reset to favour A.
REQ-014 A port requesting continuously SHALL be granted within 2 cycles.
REQ-015 In a grant cycle, M_ADDR, M_WDATA and M_WE SHALL equal the winner's X_ADDR, X_WDATA and X_WE.
REQ-016 In a cycle with no grant in ST_RUN, M_WE=0, M_ADDR=0 and M_WDATA=0.
REQ-017 After a granted read, X_RVALID SHALL be high for exactly the next cycle, with X_RDATA=M_RDATA; otherwise X_RDATA=0.
REQ-018 A granted write SHALL produce no RVALID.
REQ-019 Back-to-back grants SHALL be supported, giving one access per cycle with full throughput.
REQ-020 A write to address N followed next cycle by a read of N SHALL return the new data.

Reset
REQ-021 Asserting RST_N low SHALL immediately force all of the following:
- GNT, RVALID and INIT_DONE = 0;
- M_WE = 0, M_ADDR = 0, M_WDATA = 0;
- X_RDATA = 0;
- init counter = 0, pointer = A, state = ST_INIT.
REQ-022 A reset asserted mid-init or mid-access SHALL discard any pending RVALID, and the whole clear sequence SHALL restart after release.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the state encoding (ST_INIT, ST_RUN) and the constants ADDR_W=8, DATA_W=16 and MEM_DEPTH=256.
REQ-024 The two-way round-robin selector SHALL be a sub-module named rr_arb2, with inputs req[1:0], a pointer and an update strobe, and output gnt[1:0].
REQ-025 The memory SHALL NOT be instantiated inside the block; the top level SHALL connect M_* to mem_256x16.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Release reset with both REQs high: no GNT for 256 cycles, M_WE=1 with M_ADDR 0..255 and M_WDATA=0, then INIT_DONE=1, then A granted first.
- After init, A reads address 0x7F: A_RVALID=1 the next cycle, A_RDATA=0x0000.
- A writes 0x1234 at 0x10, then B reads 0x10 the next cycle: B_RVALID=1, B_RDATA=0x1234.
- Both REQs held for 6 cycles: grants alternate A, B, A, B, A, B.
- Reset pulsed at init count 100: outputs zero at once, and after release the clear restarts at M_ADDR=0.
- With CLEAR_ON_RESET=0: INIT_DONE=1 on the second cycle after release, and a pre-written word persists across reset.
